// File: rtl/sync_mul_seq.sv
// sync_mul_seq: sequential shift-add multiplier with valid/ready handshakes
// on both the operand and the result side.
//
// One multiplier bit is consumed per clock, LSB first. The product is ready
// WIDTH cycles after the operands are accepted and is held until the
// consumer takes it.
//
// Optional feature macro: SYNC_MUL_SIGNED_EN.
//   Defined   - signed_mode selects two's-complement operands. The multiply
//               runs on magnitudes and the sign is applied to the result.
//   Undefined - all operands are unsigned and signed_mode is not used.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   in_valid     producer offers operands a/b
//   in_ready     block can accept operands (IDLE only)
//   a, b         multiplicand / multiplier, WIDTH bits
//   signed_mode  operands are two's complement (sampled at accept)
//   out_valid    mul holds a completed product
//   out_ready    consumer takes the product
//   mul          product register, 2*WIDTH bits
//   busy         operation in progress or result waiting (CALC or DONE)
module sync_mul_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   mul,
    output logic                 busy
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state, state_nxt;
    logic [PW-1:0]      a_sh;      // multiplicand, shifted left once per CALC edge
    logic [WIDTH-1:0]   b_sh;      // multiplier, shifted right once per CALC edge
    logic [PW-1:0]      acc;
    logic [PW-1:0]      acc_nxt;
    logic [PW-1:0]      prod_fin;
    logic [CNT_W-1:0]   cnt;
    logic               last_bit;
    logic               accept;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    assign accept   = in_valid && (state == IDLE);
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    // b_sh[0] is bit cnt of the captured multiplier; a_sh is a << cnt.
    assign acc_nxt  = acc + (b_sh[0] ? a_sh : '0);

`ifdef SYNC_MUL_SIGNED_EN
    logic sign_q;
    logic sign_nxt;

    // |v| as an unsigned WIDTH-bit magnitude. The most-negative value maps
    // to 2^(WIDTH-1), which still fits.
    function automatic logic [WIDTH-1:0] abs_mag(input logic signed [WIDTH-1:0] v);
        logic signed [WIDTH-1:0] n;
        n = -v;
        return v[WIDTH-1] ? $unsigned(n) : $unsigned(v);
    endfunction

    // Apply the recorded sign to the unsigned product.
    function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] p, input logic neg);
        logic signed [PW-1:0] ps;
        ps = -$signed(p);
        return neg ? $unsigned(ps) : p;
    endfunction

    assign mag_a    = signed_mode ? abs_mag($signed(a)) : a;
    assign mag_b    = signed_mode ? abs_mag($signed(b)) : b;
    assign sign_nxt = signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
    assign prod_fin = apply_sign(acc_nxt, sign_q);

    always_ff @(posedge clk) begin
        if (accept) begin
            sign_q <= sign_nxt;
        end
    end
`else
    logic unused_signed_mode;

    assign unused_signed_mode = signed_mode;
    assign mag_a    = a;
    assign mag_b    = b;
    assign prod_fin = acc_nxt;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = CALC;
            CALC:    if (last_bit)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state only
    always_comb begin
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        out_valid = (state == DONE);
    end

    // Operand shift registers (no reset: only meaningful after an accept)
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh <= {{WIDTH{1'b0}}, mag_a};
            b_sh <= mag_b;
        end else if (state == CALC) begin
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
        end
    end

    // Accumulator, bit counter and product register
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
            mul <= '0;
        end else if (accept) begin
            acc <= '0;
            cnt <= '0;
        end else if (state == CALC) begin
            acc <= acc_nxt;
            cnt <= cnt + CNT_W'(1);
            if (last_bit) begin
                mul <= prod_fin;
            end
        end
    end

endmodule
